// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the accumulator sequencer: ALU function codes,
// opcodes and the sequencer state encoding.
package alu_sequencer_pkg;

  localparam int ALU_FW = 3;

  localparam logic [ALU_FW-1:0] ALU_PASS_A  = 3'b000;
  localparam logic [ALU_FW-1:0] ALU_COMPARE = 3'b001;
  localparam logic [ALU_FW-1:0] ALU_PASS_B  = 3'b010;
  localparam logic [ALU_FW-1:0] ALU_ADD     = 3'b011;
  localparam logic [ALU_FW-1:0] ALU_NOR     = 3'b100;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_CMPI = 4'd3;
  localparam logic [3:0] OP_NORI = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_CLRF = 4'd6;
  localparam logic [3:0] OP_MULI = 4'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL      = 2'd2,
    OUT_WAIT = 2'd3
  } state_t;

  // ALU function used while an EXEC-class opcode is in flight
  function automatic logic [ALU_FW-1:0] exec_func(input logic [3:0] op);
    case (op)
      OP_LDI:  exec_func = ALU_PASS_B;
      OP_ADDI: exec_func = ALU_ADD;
      OP_CMPI: exec_func = ALU_COMPARE;
      OP_NORI: exec_func = ALU_NOR;
      default: exec_func = ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction and output-stream handshakes of the sequencer; the sequencer
// is the slave side, the instruction source / stream consumer the master.
interface alu_sequencer_if #(
  parameter int DW  = 4,
  parameter int OPW = 4
);
  logic                instr_valid;
  logic [OPW+DW-1:0]   instr;
  logic                instr_ready;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_ready;

  modport slave (
    input  instr_valid, instr, out_ready,
    output instr_ready, out_valid, out_data
  );

  modport master (
    output instr_valid, instr, out_ready,
    input  instr_ready, out_valid, out_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator instruction sequencer driving an external 4-bit ALU, with a
// shift-free multiply by repeated ADD and an accumulator output stream.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DW  = 4,
  parameter int OPW = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    bus,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [ALU_FW-1:0] alu_f,
  output logic              alu_reset,
  input  logic [DW-1:0]     alu_y,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic [DW-1:0]     acc,
  output logic              flag_c,
  output logic              flag_z,
  output logic              busy,
  output logic              illegal
);

  state_t          state, state_next;
  logic [OPW-1:0]  opcode_q;
  logic [DW-1:0]   imm_q;
  logic [DW-1:0]   mcand, prod, cnt;
  logic            ovf;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;

  logic [OPW-1:0]  in_op;
  logic [DW-1:0]   in_imm;
  logic            accept, legal;

  assign {in_op, in_imm} = bus.instr;
  assign accept          = bus.instr_valid && (state == IDLE);
  assign legal           = ~in_op[OPW-1];
  assign alu_reset       = reset;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Idle ALU view is the accumulator, so the ALU always shows something meaningful
  always_comb begin
    state_next      = state;
    alu_a           = acc;
    alu_b           = '0;
    alu_f           = ALU_PASS_A;
    bus.instr_ready = 1'b0;
    busy            = 1'b1;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        busy            = 1'b0;
        if (accept && legal) begin
          case (in_op)
            OP_MULI: state_next = MUL;
            OP_OUT:  state_next = OUT_WAIT;
            default: state_next = EXEC;
          endcase
        end
      end
      EXEC: begin
        alu_b      = imm_q;
        alu_f      = exec_func(opcode_q);
        state_next = IDLE;
      end
      MUL: begin
        if (cnt != '0) begin
          alu_a = prod;
          alu_b = mcand;
          alu_f = ALU_ADD;
        end else begin
          state_next = IDLE;
        end
      end
      OUT_WAIT: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      illegal     <= 1'b0;
      opcode_q    <= '0;
      imm_q       <= '0;
      mcand       <= '0;
      prod        <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              illegal <= 1'b1;
            end else begin
              opcode_q <= in_op;
              imm_q    <= in_imm;
              if (in_op == OP_MULI) begin
                mcand <= acc;
                prod  <= '0;
                cnt   <= in_imm;
                ovf   <= 1'b0;
              end
              if (in_op == OP_OUT) begin
                out_data_q  <= acc;
                out_valid_q <= 1'b1;
              end
            end
          end
        end
        EXEC: begin
          case (opcode_q)
            OP_LDI: begin
              acc    <= alu_y;
              flag_c <= 1'b0;
              flag_z <= alu_z;
            end
            OP_ADDI: begin
              acc    <= alu_y;
              flag_c <= alu_c;
              flag_z <= alu_z;
            end
            OP_CMPI: begin
              flag_c <= alu_c;
              flag_z <= alu_z;
            end
            OP_NORI: begin
              acc    <= alu_y;
              flag_c <= 1'b0;
              flag_z <= alu_z;
            end
            OP_CLRF: begin
              flag_c <= 1'b0;
              flag_z <= 1'b0;
            end
            default: ;
          endcase
        end
        // The cycle that finds cnt exhausted is the write-back cycle
        MUL: begin
          if (cnt != '0) begin
            prod <= alu_y;
            ovf  <= ovf | alu_c;
            cnt  <= cnt - DW'(1);
          end else begin
            acc    <= prod;
            flag_c <= ovf;
            flag_z <= (prod == '0);
          end
        end
        OUT_WAIT: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU alongside the DUT, a vector table
// of instructions with expected write-back, and hand-built corner sequences.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  typedef struct {
    logic [7:0] instr;
    logic [3:0] exp_acc;
    logic       exp_c;
    logic       exp_z;
    int         exp_cycles;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_a, alu_b, alu_y, acc;
  logic [2:0] alu_f;
  logic       alu_reset, alu_c, alu_z;
  logic       flag_c, flag_z, busy, illegal;
  logic [4:0] alu_r;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] model_acc = 4'h0;
  logic [3:0] exp_q[$];
  logic [3:0] sb_exp;
  vec_t       vecs[$];

  alu_sequencer_if bus();

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_reset (alu_reset),
    .alu_y     (alu_y),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .acc       (acc),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .busy      (busy),
    .illegal   (illegal)
  );

  // Reference ALU: compare produces a borrow in bit 4 of the 5-bit difference
  always_comb begin
    alu_r = {1'b0, alu_a};
    case (alu_f)
      ALU_COMPARE: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_PASS_B:  alu_r = {1'b0, alu_b};
      ALU_ADD:     alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_NOR:     alu_r = {1'b0, ~(alu_a | alu_b)};
      default:     alu_r = {1'b0, alu_a};
    endcase
  end
  assign alu_y = alu_r[3:0];
  assign alu_c = alu_r[4];
  assign alu_z = (alu_r[3:0] == 4'h0);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] i, input logic [3:0] a, input logic c,
                              input logic z, input int n);
    vec_t v;
    v.instr = i; v.exp_acc = a; v.exp_c = c; v.exp_z = z; v.exp_cycles = n;
    return v;
  endfunction

  // Issue one instruction, count busy cycles and check the write-back
  task automatic applyStimulus(input vec_t v);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr       = v.instr;
    if (v.instr[7:4] == OP_OUT) exp_q.push_back(model_acc);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else      done = 1;
    end
    checkOutput($sformatf("busy_cycles[%02h]", v.instr), n, v.exp_cycles);
    checkOutput($sformatf("acc[%02h]", v.instr), acc, v.exp_acc);
    checkOutput($sformatf("flag_c[%02h]", v.instr), flag_c, v.exp_c);
    checkOutput($sformatf("flag_z[%02h]", v.instr), flag_z, v.exp_z);
    checkOutput($sformatf("instr_ready[%02h]", v.instr), bus.instr_ready, 1);
    model_acc = v.exp_acc;
  endtask

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL out_unexpected: got %0h, expected no transfer", bus.out_data);
      end else begin
        sb_exp = exp_q.pop_front();
        checkOutput("out_data", bus.out_data, sb_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back(mk(8'h19, 4'h9, 0, 0, 1));
    vecs.push_back(mk(8'h28, 4'h1, 1, 0, 1));
    vecs.push_back(mk(8'h13, 4'h3, 0, 0, 1));
    vecs.push_back(mk(8'h35, 4'h3, 1, 0, 1));
    vecs.push_back(mk(8'h33, 4'h3, 0, 1, 1));
    vecs.push_back(mk(8'h4C, 4'h0, 0, 1, 1));
    vecs.push_back(mk(8'h2F, 4'hF, 0, 0, 1));
    vecs.push_back(mk(8'h21, 4'h0, 1, 1, 1));
    vecs.push_back(mk(8'h00, 4'h0, 1, 1, 1));
    vecs.push_back(mk(8'h60, 4'h0, 0, 0, 1));
    vecs.push_back(mk(8'h1A, 4'hA, 0, 0, 1));
    vecs.push_back(mk(8'h41, 4'h4, 0, 0, 1));
    vecs.push_back(mk(8'h50, 4'h4, 0, 0, 1));
    vecs.push_back(mk(8'h13, 4'h3, 0, 0, 1));
    vecs.push_back(mk(8'h76, 4'h2, 1, 0, 7));
    vecs.push_back(mk(8'h70, 4'h0, 0, 1, 1));
    vecs.push_back(mk(8'h15, 4'h5, 0, 0, 1));
    vecs.push_back(mk(8'h73, 4'hF, 0, 0, 4));
    vecs.push_back(mk(8'h14, 4'h4, 0, 0, 1));
    vecs.push_back(mk(8'h74, 4'h0, 1, 1, 5));

    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_acc", acc, 0);
    checkOutput("rst_flag_c", flag_c, 0);
    checkOutput("rst_flag_z", flag_z, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_instr_ready", bus.instr_ready, 1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Undefined opcode: one-cycle pulse, state and flags (C=1, Z=1) untouched
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h9F;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("ill_pulse", illegal, 1);
    checkOutput("ill_ready", bus.instr_ready, 1);
    checkOutput("ill_busy", busy, 0);
    checkOutput("ill_acc", acc, 0);
    checkOutput("ill_flag_c", flag_c, 1);
    checkOutput("ill_flag_z", flag_z, 1);
    @(negedge clk);
    checkOutput("ill_pulse_end", illegal, 0);

    // OUT stalled by the consumer for three cycles
    applyStimulus(mk(8'h1A, 4'hA, 0, 0, 1));
    @(posedge clk); #1;
    bus.out_ready   = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h50;
    exp_q.push_back(4'hA);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_valid%0d", k), bus.out_valid, 1);
      checkOutput($sformatf("stall_data%0d", k), bus.out_data, 4'hA);
      checkOutput($sformatf("stall_ready%0d", k), bus.instr_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_busy_last", busy, 1);
    @(negedge clk);
    checkOutput("stall_done_valid", bus.out_valid, 0);
    checkOutput("stall_done_busy", busy, 0);
    checkOutput("stall_done_ready", bus.instr_ready, 1);

    // Reset in the third MUL cycle of MULI 7 abandons the multiply
    applyStimulus(mk(8'h13, 4'h3, 0, 0, 1));
    applyStimulus(mk(8'h35, 4'h3, 1, 0, 1));
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h77;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_acc", acc, 0);
    checkOutput("abort_flag_c", flag_c, 0);
    checkOutput("abort_flag_z", flag_z, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", bus.instr_ready, 1);
    model_acc = 4'h0;
    applyStimulus(mk(8'h14, 4'h4, 0, 0, 1));

    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Instruction sequencer that owns the 4-bit ALU and steps it through a small accumulator instruction set. It accepts 8-bit instructions over a valid/ready handshake and drives the ALU operands and function code. It writes ALU results back into an accumulator and latches the carry and zero flags. It also runs a multi-cycle multiply by repeated ADD, and streams the accumulator to a consumer over a second valid/ready port.

Parameters:
DW, 4, datapath width; fixed to ALU width, not overridable in practice
OPW, 4, opcode width; instr = {opcode[OPW-1:0], imm[DW-1:0]}

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
instr_valid  in  1  instruction offered
instr  in  8  {opcode[7:4], imm[3:0]}
instr_ready  out  1  sequencer can accept; high only in IDLE
alu_a  out  4  ALU operand a
alu_b  out  4  ALU operand b
alu_f  out  3  ALU function: 000 pass_a, 001 compare(a-b), 010 pass_b, 011 add, 100 nor
alu_reset  out  1  driven = reset
alu_y  in  4  ALU result
alu_c  in  1  ALU carry/borrow
alu_z  in  1  ALU zero
acc  out  4  accumulator
flag_c  out  1  latched carry
flag_z  out  1  latched zero
out_valid  out  1  output data valid
out_data  out  4  output data (accumulator snapshot)
out_ready  in  1  consumer accepts
busy  out  1  high whenever state != IDLE
illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset values: acc=0, flag_c=0, flag_z=0, out_valid=0, out_data=0, illegal=0, busy=0, instr_ready=1, state=IDLE.
- States: IDLE, EXEC, MUL, OUT_WAIT.
- Accept: instr_valid & instr_ready in IDLE registers opcode and imm.
  - Next state is EXEC, MUL (opcode 7) or OUT_WAIT (opcode 5).
  - Opcodes 8-15: stay in IDLE, pulse illegal for 1 cycle, no other state change.
- Opcodes: 0 NOP, 1 LDI, 2 ADDI, 3 CMPI, 4 NORI, 5 OUT, 6 CLRF, 7 MULI.
- EXEC (1 cycle): alu_a=acc, alu_b=imm, alu_f per opcode. At the closing edge:
  - LDI: acc<=alu_y (pass_b); flag_z<=alu_z; flag_c<=0.
  - ADDI: acc<=alu_y; flag_c<=alu_c (bit 4 of sum); flag_z<=alu_z.
  - CMPI: acc unchanged; flag_c<=alu_c (borrow, 1 iff acc<imm); flag_z<=alu_z (1 iff acc==imm).
  - NORI: acc<=alu_y; flag_c<=0; flag_z<=alu_z.
  - NOP: no change. CLRF: flag_c<=0, flag_z<=0.
  - Then return to IDLE.
- Timing: an instruction accepted at edge N writes back at edge N+1; instr_ready is high again in cycle N+1. Peak throughput is 1 instruction per 2 cycles.
- MULI:
  - On accept: mcand<=acc, prod<=0, cnt<=imm, ovf<=0.
  - Each MUL cycle with cnt!=0: alu_a=prod, alu_b=mcand, alu_f=add; prod<=alu_y, ovf<=ovf|alu_c, cnt<=cnt-1.
  - Leave MUL on the cycle cnt==0: acc<=prod, flag_c<=ovf, flag_z<=(prod==0).
  - imm=0 takes 1 MUL cycle with result 0, Z=1, C=0. Busy MUL cycles = max(imm,1)+... exactly imm+1 cycles (the last one is write-back).
  - Result = (acc*imm) mod 16.
- OUT: on accept, out_data<=acc and out_valid<=1. Hold both stable until out_valid & out_ready, then clear out_valid and return to IDLE. out_ready may be high on the first valid cycle.
- Outside EXEC/MUL: alu_a=acc, alu_b=0, alu_f=pass_a (ALU shows acc).
- Reset asserted in any state aborts the operation immediately: MUL partial product discarded, pending out_valid dropped, all outputs to reset values on the next edge.
- instr_valid while busy is ignored; the upstream holds instr until accepted.

Decomposition:
- Shared package: alu function-code constants (PASS_A, COMPARE, PASS_B, ADD, NOR); opcode constants OP_NOP..OP_MULI; state enum encoding.
- No sub-module. The ALU is instantiated alongside the sequencer at the next level up, not inside it.

Test Plan:
- Reset, LDI 9, ADDI 8 -> acc=1, flag_c=1, flag_z=0; each instruction writes back 1 cycle after accept.
- acc=3, CMPI 5 -> flag_c=1, flag_z=0, acc=3. Then CMPI 3 -> flag_c=0, flag_z=1.
- acc=3, MULI 6 -> busy for 7 cycles; acc=2 (18 mod 16), flag_c=1, flag_z=0. Then MULI 0 -> acc=0, flag_z=1, 1 busy cycle.
- acc=0xA, OUT with out_ready low for 3 cycles -> out_valid=1 and out_data=0xA held 3 cycles. instr_ready=0 throughout; completes on the cycle ready rises.
- Instruction 0x9F -> illegal pulses exactly 1 cycle; acc and flags unchanged; instr_ready stays 1.
- Reset asserted on the 3rd cycle of MULI 7 -> next cycle acc=0, flags=0, busy=0, instr_ready=1; a following LDI 4 executes normally.
